// File: rtl/spike_rate_encoder.sv
// Spike rate encoder: accepts one intensity per valid/ready handshake and
// emits a spike train over a fixed window of WINDOW_LEN cycles using a
// first-order phase accumulator. A spike is the carry out of acc + intensity,
// so the spike density equals intensity / 2^WIDTH.
module spike_rate_encoder #(
  parameter int WIDTH      = 8,
  parameter int WINDOW_LEN = 256,
  parameter int CNT_W      = $clog2(WINDOW_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,          // asynchronous, active-low
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] intensity,
  input  logic             halt,
  output logic             syn,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] spike_count
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ENCODE = 2'd1,
    ST_REPORT = 2'd2
  } state_e;

  // Window counter value seen on the final encode edge of a window.
  localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(WINDOW_LEN - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] int_q, int_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] win_q, win_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             syn_q, syn_d;

  logic             accept_s;
  logic             last_s;
  logic [WIDTH:0]   sum_s;

  assign accept_s = in_valid && (state_q == ST_IDLE);
  assign last_s   = (win_q == WIN_LAST);
  // The carry bit of this sum is the spike for the current encode edge.
  assign sum_s    = {1'b0, acc_q} + {1'b0, int_q};

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: halt only matters while encoding; REPORT always lasts one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d = ST_ENCODE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ENCODE: begin
        if (halt) begin
          state_d = ST_IDLE;
        end else if (last_s) begin
          state_d = ST_REPORT;
        end else begin
          state_d = ST_ENCODE;
        end
      end
      ST_REPORT: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Status outputs decoded straight from the state register.
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
      end
      ST_ENCODE: begin
        busy = 1'b1;
      end
      ST_REPORT: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

  // Datapath next values: latch on acceptance, accumulate while encoding,
  // and clear syn on leaving ENCODE (halt) or REPORT.
  always_comb begin
    int_d = int_q;
    acc_d = acc_q;
    win_d = win_q;
    cnt_d = cnt_q;
    syn_d = syn_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          int_d = intensity;
          acc_d = '0;
          win_d = '0;
          cnt_d = '0;
          syn_d = 1'b0;
        end else begin
          syn_d = 1'b0;
        end
      end
      ST_ENCODE: begin
        if (halt) begin
          syn_d = 1'b0;
        end else begin
          acc_d = sum_s[WIDTH-1:0];
          syn_d = sum_s[WIDTH];
          cnt_d = cnt_q + CNT_W'(sum_s[WIDTH]);
          win_d = win_q + CNT_W'(1);
        end
      end
      ST_REPORT: begin
        syn_d = 1'b0;
      end
      default: begin
        syn_d = 1'b0;
      end
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      int_q <= '0;
      acc_q <= '0;
      win_q <= '0;
      cnt_q <= '0;
      syn_q <= 1'b0;
    end else begin
      int_q <= int_d;
      acc_q <= acc_d;
      win_q <= win_d;
      cnt_q <= cnt_d;
      syn_q <= syn_d;
    end
  end

  assign syn         = syn_q;
  assign spike_count = cnt_q;

endmodule

// File: tb/tb_spike_rate_encoder.sv
// Self-checking bench for spike_rate_encoder. The reference model states the
// expected behaviour directly: after k encode edges the spike count is
// floor(k*I/256), and the spike on edge k is the difference of two such terms.
module tb_spike_rate_encoder;

  localparam int W = 256;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] intensity;
  logic       halt;
  logic       syn;
  logic       busy;
  logic       done;
  logic [8:0] spike_count;

  logic       in_valid_1;
  logic       in_ready_1;
  logic [7:0] intensity_1;
  logic       halt_1;
  logic       syn_1;
  logic       busy_1;
  logic       done_1;
  logic [0:0] spike_count_1;

  int checks;
  int failures;

  spike_rate_encoder #(.WIDTH(8), .WINDOW_LEN(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .intensity(intensity), .halt(halt), .syn(syn), .busy(busy),
    .done(done), .spike_count(spike_count)
  );

  spike_rate_encoder #(.WIDTH(8), .WINDOW_LEN(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid_1), .in_ready(in_ready_1),
    .intensity(intensity_1), .halt(halt_1), .syn(syn_1), .busy(busy_1),
    .done(done_1), .spike_count(spike_count_1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int inten;
    int halt_at;   // 0 = run to completion, k = halt raised before encode edge k
    bit halt_acc;  // halt held high on the acceptance edge
    int exp_count; // final spike_count expected after the window
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int model_count(input int k, input int iv);
    return (k * iv) / 256;
  endfunction

  task automatic wait_ready();
    int n;
    n = 0;
    while (!in_ready && n < 1000) begin
      tick();
      n++;
    end
    check("wait_ready", int'(in_ready), 1);
  endtask

  // Run one request through the main encoder and compare every cycle against the model.
  task automatic run_window(input int iv, input int halt_at, input bit halt_acc,
                            input bit wiggle, output int final_cnt);
    bit aborted;
    aborted = 1'b0;
    wait_ready();
    in_valid  = 1'b1;
    intensity = iv[7:0];
    halt      = halt_acc;
    tick();
    in_valid = 1'b0;
    halt     = 1'b0;
    check("accept_busy", int'(busy), 1);
    check("accept_ready", int'(in_ready), 0);
    check("accept_syn", int'(syn), 0);
    check("accept_count", int'(spike_count), 0);
    for (int k = 1; k <= W; k++) begin
      if (wiggle) begin
        intensity = 8'($urandom);
        in_valid  = 1'($urandom_range(0, 1));
      end
      if (k == halt_at) halt = 1'b1;
      tick();
      halt     = 1'b0;
      in_valid = 1'b0;
      if (k == halt_at) begin
        check("halt_ready", int'(in_ready), 1);
        check("halt_syn", int'(syn), 0);
        check("halt_done", int'(done), 0);
        check("halt_count", int'(spike_count), model_count(k - 1, iv));
        aborted = 1'b1;
        break;
      end
      check("enc_syn", int'(syn), model_count(k, iv) - model_count(k - 1, iv));
      check("enc_count", int'(spike_count), model_count(k, iv));
      check("enc_done", int'(done), (k == W) ? 1 : 0);
    end
    if (!aborted) begin
      if (wiggle) begin
        halt     = 1'($urandom_range(0, 1));
        in_valid = 1'($urandom_range(0, 1));
      end
      tick();
      halt     = 1'b0;
      in_valid = 1'b0;
      check("post_done", int'(done), 0);
      check("post_ready", int'(in_ready), 1);
      check("post_syn", int'(syn), 0);
      check("post_count", int'(spike_count), model_count(W, iv));
    end
    final_cnt = int'(spike_count);
  endtask

  initial begin
    int fc;
    int edge_n;
    int acc_edges[$];
    bit rdy;

    checks      = 0;
    failures    = 0;
    rst         = 1'b0;
    in_valid    = 1'b0;
    intensity   = 8'd0;
    halt        = 1'b0;
    in_valid_1  = 1'b0;
    intensity_1 = 8'd0;
    halt_1      = 1'b0;

    vecs.push_back('{inten: 128, halt_at: 0,   halt_acc: 1'b0, exp_count: 128});
    vecs.push_back('{inten: 0,   halt_at: 0,   halt_acc: 1'b0, exp_count: 0});
    vecs.push_back('{inten: 255, halt_at: 0,   halt_acc: 1'b0, exp_count: 255});
    vecs.push_back('{inten: 64,  halt_at: 10,  halt_acc: 1'b0, exp_count: 2});
    vecs.push_back('{inten: 1,   halt_at: 0,   halt_acc: 1'b1, exp_count: 1});
    vecs.push_back('{inten: 200, halt_at: 0,   halt_acc: 1'b0, exp_count: 200});
    vecs.push_back('{inten: 64,  halt_at: 1,   halt_acc: 1'b0, exp_count: 0});
    vecs.push_back('{inten: 255, halt_at: 256, halt_acc: 1'b0, exp_count: 254});
    vecs.push_back('{inten: 37,  halt_at: 0,   halt_acc: 1'b0, exp_count: 37});

    #2;
    check("rst_ready", int'(in_ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_syn", int'(syn), 0);
    check("rst_count", int'(spike_count), 0);
    tick();
    rst = 1'b1;
    tick();

    // Table-driven windows, including halt at edge 10 followed by fresh requests.
    foreach (vecs[i]) begin
      run_window(vecs[i].inten, vecs[i].halt_at, vecs[i].halt_acc, 1'b0, fc);
      check("table_final_count", fc, vecs[i].exp_count);
    end

    // Handshake: in_valid held high across two requests.
    wait_ready();
    in_valid  = 1'b1;
    intensity = 8'd10;
    edge_n    = 0;
    for (int c = 0; c < 700 && acc_edges.size() < 2; c++) begin
      rdy = in_ready;
      tick();
      edge_n++;
      if (rdy) acc_edges.push_back(edge_n);
      if (acc_edges.size() == 1 && edge_n > acc_edges[0]) begin
        if (edge_n - acc_edges[0] <= W) begin
          check("hs_ready_low", int'(in_ready), 0);
        end else begin
          check("hs_ready_high", int'(in_ready), 1);
        end
      end
    end
    in_valid = 1'b0;
    if (acc_edges.size() == 2) begin
      check("hs_spacing", acc_edges[1] - acc_edges[0], W + 2);
    end else begin
      check("hs_accept_count", acc_edges.size(), 2);
    end
    wait_ready();
    check("hs_final_count", int'(spike_count), model_count(W, 10));

    // Asynchronous reset in the middle of a window.
    in_valid  = 1'b1;
    intensity = 8'd128;
    tick();
    in_valid = 1'b0;
    repeat (20) tick();
    check("pre_rst_count", int'(spike_count), model_count(20, 128));
    #2 rst = 1'b0;
    #1;
    check("mid_rst_syn", int'(syn), 0);
    check("mid_rst_done", int'(done), 0);
    check("mid_rst_count", int'(spike_count), 0);
    check("mid_rst_ready", int'(in_ready), 1);
    check("mid_rst_busy", int'(busy), 0);
    #2 rst = 1'b1;
    tick();
    check("post_rst_ready", int'(in_ready), 1);
    check("post_rst_done", int'(done), 0);

    // Single-cycle window on the WINDOW_LEN=1 instance.
    check("w1_ready", int'(in_ready_1), 1);
    in_valid_1  = 1'b1;
    intensity_1 = 8'd200;
    tick();
    in_valid_1 = 1'b0;
    check("w1_busy", int'(busy_1), 1);
    check("w1_done_enc", int'(done_1), 0);
    tick();
    check("w1_done", int'(done_1), 1);
    check("w1_syn", int'(syn_1), 0);
    check("w1_count", int'(spike_count_1), 0);
    tick();
    check("w1_done_after", int'(done_1), 0);
    check("w1_idle", int'(in_ready_1), 1);

    // Randomised windows with input wiggling during encode and optional halts.
    for (int r = 0; r < 10; r++) begin
      int iv;
      int ha;
      iv = int'($urandom_range(0, 255));
      ha = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, W)) : 0;
      run_window(iv, ha, 1'($urandom_range(0, 1)), 1'b1, fc);
      check("rand_final_count", fc, (ha == 0) ? model_count(W, iv) : model_count(ha - 1, iv));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
